// File: rtl/mshr_refill_ctrl.sv
// Miss-handling sequencer: merges or allocates misses, issues refills round-robin, and returns lines to the cache.
// Optional performance counters are enabled by defining MSHR_CTRL_PERF_EN.
module mshr_refill_ctrl #(
  parameter int N_ENTRIES  = 2,
  parameter int KEY_WIDTH  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = (N_ENTRIES <= 1) ? 1 : $clog2(N_ENTRIES)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [KEY_WIDTH-1:0]           miss_key_i,
  input  logic [DATA_WIDTH-1:0]          miss_tag_i,
  output logic                           miss_merged_o,
  output logic [IDX_WIDTH-1:0]           miss_idx_o,
  output logic                           mshr_alloc_valid_o,
  input  logic                           mshr_alloc_ready_i,
  input  logic [IDX_WIDTH-1:0]           mshr_alloc_idx_i,
  output logic [KEY_WIDTH-1:0]           mshr_alloc_key_o,
  output logic [DATA_WIDTH-1:0]          mshr_alloc_data_o,
  output logic                           mshr_dealloc_valid_o,
  output logic [IDX_WIDTH-1:0]           mshr_dealloc_idx_o,
  output logic                           mshr_flush_o,
  input  logic [N_ENTRIES-1:0]           mshr_entry_valid_i,
  input  logic [N_ENTRIES*KEY_WIDTH-1:0] mshr_entry_key_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [KEY_WIDTH-1:0]           mem_req_addr_o,
  output logic [IDX_WIDTH-1:0]           mem_req_id_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [IDX_WIDTH-1:0]           mem_rsp_id_i,
  output logic                           mem_rsp_ready_o,
  output logic                           refill_valid_o,
  input  logic                           refill_ready_i,
  output logic [IDX_WIDTH-1:0]           refill_idx_o,
  output logic [KEY_WIDTH-1:0]           refill_key_o
`ifdef MSHR_CTRL_PERF_EN
  ,
  output logic [31:0]                    perf_alloc_o,
  output logic [31:0]                    perf_merge_o,
  output logic [31:0]                    perf_stall_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ISSUED, ST_DONE} ent_st_e;

  ent_st_e              state_q [N_ENTRIES];
  ent_st_e              state_d [N_ENTRIES];
  logic [IDX_WIDTH-1:0] rr_q, rr_d;
  logic                 lock_q, lock_d;
  logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;

  logic                 match_hit;
  logic [IDX_WIDTH-1:0] match_idx;
  ent_st_e              match_st;
  logic                 merge;
  logic                 alloc_fire;
  logic                 pend_any;
  logic [IDX_WIDTH-1:0] gnt_idx;
  logic [KEY_WIDTH-1:0] gnt_key;
  logic                 mem_fire;
  logic                 done_any;
  logic [IDX_WIDTH-1:0] done_idx;
  logic [KEY_WIDTH-1:0] done_key;
  logic                 refill_fire;

  // Lookup of the miss against live entries (lowest index wins)
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    match_st  = ST_IDLE;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!match_hit && mshr_entry_valid_i[i] && state_q[i] != ST_IDLE &&
          mshr_entry_key_i[i*KEY_WIDTH +: KEY_WIDTH] == miss_key_i) begin
        match_hit = 1'b1;
        match_idx = IDX_WIDTH'(i);
        match_st  = state_q[i];
      end
    end
  end

  // Round-robin pick among PEND entries; a stalled request keeps its grant
  always_comb begin
    pend_any = 1'b0;
    gnt_idx  = '0;
    for (int k = 0; k < N_ENTRIES; k++) begin
      if (!pend_any && state_q[(int'(rr_q) + k) % N_ENTRIES] == ST_PEND) begin
        pend_any = 1'b1;
        gnt_idx  = IDX_WIDTH'((int'(rr_q) + k) % N_ENTRIES);
      end
    end
    if (lock_q) begin
      gnt_idx = lock_idx_q;
    end
    done_any = 1'b0;
    done_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!done_any && state_q[i] == ST_DONE) begin
        done_any = 1'b1;
        done_idx = IDX_WIDTH'(i);
      end
    end
    gnt_key  = '0;
    done_key = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (IDX_WIDTH'(i) == gnt_idx)  gnt_key  = mshr_entry_key_i[i*KEY_WIDTH +: KEY_WIDTH];
      if (IDX_WIDTH'(i) == done_idx) done_key = mshr_entry_key_i[i*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  always_comb begin
    merge = miss_valid_i && !flush_i && match_hit &&
            (match_st == ST_PEND || match_st == ST_ISSUED);
    mshr_alloc_valid_o = miss_valid_i && !flush_i && !match_hit;
    alloc_fire         = mshr_alloc_valid_o && mshr_alloc_ready_i;
    miss_ready_o       = merge || alloc_fire;
    miss_merged_o      = merge;
    miss_idx_o         = merge ? match_idx : (mshr_alloc_valid_o ? mshr_alloc_idx_i : '0);
    mshr_alloc_key_o   = miss_key_i;
    mshr_alloc_data_o  = miss_tag_i;
    mshr_flush_o       = flush_i;

    mem_req_valid_o = pend_any && !flush_i;
    mem_req_addr_o  = mem_req_valid_o ? gnt_key : '0;
    mem_req_id_o    = mem_req_valid_o ? gnt_idx : '0;
    mem_fire        = mem_req_valid_o && mem_req_ready_i;
    mem_rsp_ready_o = 1'b1;

    refill_valid_o       = done_any && !flush_i;
    refill_idx_o         = refill_valid_o ? done_idx : '0;
    refill_key_o         = refill_valid_o ? done_key : '0;
    refill_fire          = refill_valid_o && refill_ready_i;
    mshr_dealloc_valid_o = refill_fire;
    mshr_dealloc_idx_o   = refill_fire ? done_idx : '0;
  end

  // Entry lifecycle; later assignments take priority (alloc beats dealloc, flush beats all)
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      if (mem_rsp_valid_i && mem_rsp_id_i == IDX_WIDTH'(i) && state_q[i] == ST_ISSUED)
        state_d[i] = ST_DONE;
      if (mem_fire && gnt_idx == IDX_WIDTH'(i))
        state_d[i] = ST_ISSUED;
      if (refill_fire && done_idx == IDX_WIDTH'(i))
        state_d[i] = ST_IDLE;
      if (alloc_fire && mshr_alloc_idx_i == IDX_WIDTH'(i))
        state_d[i] = ST_PEND;
      if (flush_i)
        state_d[i] = ST_IDLE;
    end
    rr_d = rr_q;
    if (mem_fire)
      rr_d = (gnt_idx == IDX_WIDTH'(N_ENTRIES - 1)) ? '0 : gnt_idx + 1'b1;
    lock_d     = mem_req_valid_o && !mem_req_ready_i;
    lock_idx_d = gnt_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) state_q[i] <= ST_IDLE;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef MSHR_CTRL_PERF_EN
  logic [31:0] perf_alloc_q, perf_alloc_d;
  logic [31:0] perf_merge_q, perf_merge_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_alloc_d = perf_alloc_q + (alloc_fire ? 32'd1 : 32'd0);
    perf_merge_d = perf_merge_q + (merge ? 32'd1 : 32'd0);
    perf_stall_d = perf_stall_q + ((miss_valid_i && !miss_ready_o) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_alloc_q <= '0;
      perf_merge_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_alloc_q <= perf_alloc_d;
      perf_merge_q <= perf_merge_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_alloc_o = perf_alloc_q;
  assign perf_merge_o = perf_merge_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mshr_refill_ctrl.sv
// Directed bench for mshr_refill_ctrl: a small MSHR store model, a per-cycle reference model and literal spot checks.
module tb_mshr_refill_ctrl;
  localparam int N  = 2;
  localparam int KW = 32;
  localparam int DW = 64;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, flush_i = 1'b0;
  logic          miss_valid_i = 1'b0;
  logic [KW-1:0] miss_key_i = '0;
  logic [DW-1:0] miss_tag_i = '0;
  logic          mem_req_ready_i = 1'b0, mem_rsp_valid_i = 1'b0, refill_ready_i = 1'b0;
  logic [IW-1:0] mem_rsp_id_i = '0;
  logic          miss_ready_o, miss_merged_o, mshr_alloc_valid_o, mshr_dealloc_valid_o, mshr_flush_o;
  logic [IW-1:0] miss_idx_o, mshr_dealloc_idx_o, mem_req_id_o, refill_idx_o;
  logic [KW-1:0] mshr_alloc_key_o, mem_req_addr_o, refill_key_o;
  logic [DW-1:0] mshr_alloc_data_o;
  logic          mem_req_valid_o, mem_rsp_ready_o, refill_valid_o;
  logic          env_ready;
  logic [IW-1:0] env_idx;
  logic          env_found;
  logic [N-1:0]  entry_valid;
  logic [N*KW-1:0] entry_key;
  logic          env_v [N];
  logic [KW-1:0] env_k [N];
`ifdef MSHR_CTRL_PERF_EN
  logic [31:0]   perf_alloc_o, perf_merge_o, perf_stall_o;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mshr_refill_ctrl #(.N_ENTRIES(N), .KEY_WIDTH(KW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_key_i(miss_key_i),
    .miss_tag_i(miss_tag_i), .miss_merged_o(miss_merged_o), .miss_idx_o(miss_idx_o),
    .mshr_alloc_valid_o(mshr_alloc_valid_o), .mshr_alloc_ready_i(env_ready),
    .mshr_alloc_idx_i(env_idx), .mshr_alloc_key_o(mshr_alloc_key_o),
    .mshr_alloc_data_o(mshr_alloc_data_o), .mshr_dealloc_valid_o(mshr_dealloc_valid_o),
    .mshr_dealloc_idx_o(mshr_dealloc_idx_o), .mshr_flush_o(mshr_flush_o),
    .mshr_entry_valid_i(entry_valid), .mshr_entry_key_i(entry_key),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_id_i(mem_rsp_id_i),
    .mem_rsp_ready_o(mem_rsp_ready_o), .refill_valid_o(refill_valid_o),
    .refill_ready_i(refill_ready_i), .refill_idx_o(refill_idx_o), .refill_key_o(refill_key_o)
`ifdef MSHR_CTRL_PERF_EN
    , .perf_alloc_o(perf_alloc_o), .perf_merge_o(perf_merge_o), .perf_stall_o(perf_stall_o)
`endif
  );

  // MSHR store: lowest free slot, else the slot being freed this cycle
  always_comb begin
    env_ready = 1'b0;
    env_idx   = '0;
    env_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      entry_valid[i] = env_v[i];
      entry_key[i*KW +: KW] = env_k[i];
      if (!env_found && !env_v[i]) begin
        env_found = 1'b1;
        env_ready = 1'b1;
        env_idx   = IW'(i);
      end
    end
    if (!env_found && mshr_dealloc_valid_o) begin
      env_ready = 1'b1;
      env_idx   = mshr_dealloc_idx_o;
    end
  end

  always @(posedge clk) begin
    if (rst_i || mshr_flush_o) begin
      for (int i = 0; i < N; i++) begin
        env_v[i] <= 1'b0;
        env_k[i] <= '0;
      end
    end else begin
      if (mshr_dealloc_valid_o) env_v[mshr_dealloc_idx_o] <= 1'b0;
      if (mshr_alloc_valid_o && env_ready) begin
        env_v[env_idx] <= 1'b1;
        env_k[env_idx] <= mshr_alloc_key_o;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference model: entry life stage 0=free 1=waiting 2=at memory 3=returned
  int ms [N] = '{0, 0};
  int ns [N];
  int mrr = 0;
  bit mlock = 0;
  int mlg = 0;
  bit e_hit, e_merge, e_av, e_afire, e_mv, e_rv, e_dv;
  int e_mi, e_g, e_d;

  always @(negedge clk) begin
    e_hit = 0; e_mi = 0;
    for (int i = 0; i < N; i++)
      if (!e_hit && env_v[i] && env_k[i] == miss_key_i && ms[i] != 0) begin
        e_hit = 1; e_mi = i;
      end
    e_merge = miss_valid_i && !flush_i && e_hit && (ms[e_mi] == 1 || ms[e_mi] == 2);
    e_av    = miss_valid_i && !flush_i && !e_hit;
    e_afire = e_av && env_ready;
    e_mv = 0; e_g = 0;
    if (mlock) begin
      e_mv = 1; e_g = mlg;
    end else begin
      for (int k = 0; k < N; k++)
        if (!e_mv && ms[(mrr + k) % N] == 1) begin
          e_mv = 1; e_g = (mrr + k) % N;
        end
    end
    e_mv = e_mv && !flush_i;
    e_rv = 0; e_d = 0;
    for (int i = N - 1; i >= 0; i--)
      if (ms[i] == 3) begin
        e_rv = 1; e_d = i;
      end
    e_rv = e_rv && !flush_i;
    e_dv = e_rv && refill_ready_i;

    chk("m_miss_ready", miss_ready_o, e_merge || e_afire);
    chk("m_merged", miss_merged_o, e_merge);
    chk("m_miss_idx", miss_idx_o, e_merge ? e_mi : (e_av ? env_idx : 0));
    chk("m_alloc_valid", mshr_alloc_valid_o, e_av);
    chk("m_alloc_key", mshr_alloc_key_o, miss_key_i);
    chk("m_alloc_data", mshr_alloc_data_o, miss_tag_i);
    chk("m_flush", mshr_flush_o, flush_i);
    chk("m_req_valid", mem_req_valid_o, e_mv);
    if (e_mv) begin
      chk("m_req_id", mem_req_id_o, e_g);
      chk("m_req_addr", mem_req_addr_o, env_k[e_g]);
    end
    chk("m_rsp_ready", mem_rsp_ready_o, 1);
    chk("m_refill_valid", refill_valid_o, e_rv);
    if (e_rv) begin
      chk("m_refill_idx", refill_idx_o, e_d);
      chk("m_refill_key", refill_key_o, env_k[e_d]);
    end
    chk("m_dealloc_valid", mshr_dealloc_valid_o, e_dv);
    if (e_dv) chk("m_dealloc_idx", mshr_dealloc_idx_o, e_d);

    if (rst_i) begin
      for (int i = 0; i < N; i++) ms[i] = 0;
      mrr = 0; mlock = 0;
    end else if (flush_i) begin
      for (int i = 0; i < N; i++) ms[i] = 0;
      mlock = 0;
    end else begin
      ns = ms;
      if (mem_rsp_valid_i && ms[mem_rsp_id_i] == 2) ns[mem_rsp_id_i] = 3;
      if (e_mv && mem_req_ready_i) begin
        ns[e_g] = 2;
        mrr = (e_g + 1) % N;
      end
      if (e_dv) ns[e_d] = 0;
      if (e_afire) ns[env_idx] = 1;
      mlock = e_mv && !mem_req_ready_i;
      mlg = e_g;
      ms = ns;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic v, input logic [KW-1:0] k);
    miss_valid_i = v;
    miss_key_i   = k;
    miss_tag_i   = {32'h7A6, k};
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_miss_ready", miss_ready_o, 0);
    chk("rst_req_valid", mem_req_valid_o, 0);
    chk("rst_refill_valid", refill_valid_o, 0);
    chk("rst_rsp_ready", mem_rsp_ready_o, 1);

    nxt(); miss(1, 32'h100);
    @(negedge clk);
    chk("a0_alloc", mshr_alloc_valid_o, 1);
    chk("a0_ready", miss_ready_o, 1);
    chk("a0_merged", miss_merged_o, 0);
    chk("a0_idx", miss_idx_o, 0);
    chk("a0_no_req_yet", mem_req_valid_o, 0);

    nxt(); miss(1, 32'h200);
    @(negedge clk);
    chk("a1_idx", miss_idx_o, 1);
    chk("iss0_valid", mem_req_valid_o, 1);
    chk("iss0_addr", mem_req_addr_o, 32'h100);
    chk("iss0_id", mem_req_id_o, 0);

    nxt(); miss(0, 0); mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("iss_a_id", mem_req_id_o, 0);
    nxt();
    @(negedge clk);
    chk("iss_b_id", mem_req_id_o, 1);
    chk("iss_b_addr", mem_req_addr_o, 32'h200);

    nxt(); miss(1, 32'h100);
    @(negedge clk);
    chk("merge_ready", miss_ready_o, 1);
    chk("merge_flag", miss_merged_o, 1);
    chk("merge_idx", miss_idx_o, 0);
    chk("merge_no_alloc", mshr_alloc_valid_o, 0);
    chk("merge_no_req", mem_req_valid_o, 0);

    nxt(); miss(0, 0); mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 1'b1;
    @(negedge clk);
    chk("rsp1_no_refill", refill_valid_o, 0);
    nxt(); mem_rsp_id_i = 1'b0; refill_ready_i = 1'b1;
    @(negedge clk);
    chk("ref1_idx", refill_idx_o, 1);
    chk("ref1_key", refill_key_o, 32'h200);
    chk("ref1_dealloc", mshr_dealloc_valid_o, 1);
    nxt(); mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("ref0_idx", refill_idx_o, 0);
    chk("ref0_dealloc_idx", mshr_dealloc_idx_o, 0);

    nxt(); refill_ready_i = 1'b0; miss(1, 32'h300);
    nxt(); miss(1, 32'h400);
    @(negedge clk);
    chk("re_iss_addr", mem_req_addr_o, 32'h300);
    nxt(); miss(0, 0);
    nxt(); mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 1'b0;
    nxt(); mem_rsp_valid_i = 1'b0; refill_ready_i = 1'b1; miss(1, 32'h200);
    @(negedge clk);
    chk("reuse_dealloc", mshr_dealloc_valid_o, 1);
    chk("reuse_alloc", mshr_alloc_valid_o, 1);
    chk("reuse_ready", miss_ready_o, 1);
    chk("reuse_idx", miss_idx_o, 0);
    nxt(); miss(0, 0);
    @(negedge clk);
    chk("reuse_req_id", mem_req_id_o, 0);
    chk("reuse_req_addr", mem_req_addr_o, 32'h200);

    nxt(); refill_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 1'b1;
    nxt(); mem_rsp_valid_i = 1'b0; miss(1, 32'h400);
    @(negedge clk);
    chk("stall_ready", miss_ready_o, 0);
    chk("stall_no_alloc", mshr_alloc_valid_o, 0);
    nxt(); refill_ready_i = 1'b1;
    @(negedge clk);
    chk("stall_ready2", miss_ready_o, 0);
    chk("stall_dealloc_idx", mshr_dealloc_idx_o, 1);
    nxt();
    @(negedge clk);
    chk("unstall_ready", miss_ready_o, 1);
    chk("unstall_idx", miss_idx_o, 1);
    nxt(); miss(0, 0);

    nxt(); flush_i = 1'b1; miss(1, 32'h700);
    @(negedge clk);
    chk("fl_out", mshr_flush_o, 1);
    chk("fl_miss_ready", miss_ready_o, 0);
    chk("fl_req_valid", mem_req_valid_o, 0);
    nxt(); flush_i = 1'b0; miss(0, 0); mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 1'b0;
    nxt(); mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_rsp_dropped", refill_valid_o, 0);

    nxt(); mem_req_ready_i = 1'b0; miss(1, 32'h500);
    nxt(); miss(0, 0); rst_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_req", mem_req_valid_o, 1);
    nxt(); rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_req", mem_req_valid_o, 0);
    repeat (2) nxt();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
